// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the multiply-accumulate datapath: format constants,
// FSM state encoding and the unpacked-operand record with its unpack helper.
package fp32_pkg;

  localparam int          BIAS    = 127;
  localparam int          EXP_MAX = 255;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_ALIGN  = 3'd2,
    ST_ADD    = 3'd3,
    ST_NORM   = 3'd4,
    ST_ROUND  = 3'd5
  } state_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic        is_nan;
    logic        is_inf;
    logic        is_zero;
  } fp32_unpacked_t;

  // Subnormals are flushed: exp=0 always yields a zero mantissa.
  function automatic fp32_unpacked_t fp32_unpack(input logic [31:0] x);
    fp32_unpacked_t u;
    u.sign    = x[31];
    u.exp     = x[30:23];
    u.is_nan  = (x[30:23] == 8'(EXP_MAX)) && (x[22:0] != 23'd0);
    u.is_inf  = (x[30:23] == 8'(EXP_MAX)) && (x[22:0] == 23'd0);
    u.is_zero = (x[30:23] == 8'd0);
    u.mant    = u.is_zero ? 24'd0 : {1'b1, x[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp32_lzc.sv
// Combinational 28-bit leading-zero counter with an all-zero flag.
module fp32_lzc (
  input  logic [27:0] in_i,
  output logic [4:0]  count_o,
  output logic        zero_o
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count_o = 5'd28;
    zero_o  = 1'b1;
    for (int i = 0; i < 28; i++) begin
      if (in_i[i]) begin
        count_o = 5'(27 - i);
        zero_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp32add.sv
// Five-cycle FP32 adder (round-to-nearest-even) sharing the en/ready handshake
// of fp32mult so products can be forwarded straight into it.
module fp32add
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        en,
  output logic [31:0] y,
  output logic        ready
);

  state_e      state_q, state_d;
  logic [31:0] x1_q, x2_q;
  logic        a_sign_q, b_sign_q;
  logic [7:0]  a_exp_q, b_exp_q;
  logic [23:0] a_mant_q, b_mant_q;
  logic        special_q;
  logic [31:0] special_val_q;
  logic [26:0] mb_q;
  logic [27:0] sum_q;
  logic [26:0] mant_q;
  logic [9:0]  exp_q;
  logic        zero_q, sign_q;
  logic [31:0] y_q;
  logic        ready_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (en) state_d = ST_UNPACK;
      ST_UNPACK: state_d = ST_ALIGN;
      ST_ALIGN:  state_d = ST_ADD;
      ST_ADD:    state_d = ST_NORM;
      ST_NORM:   state_d = ST_ROUND;
      ST_ROUND:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Unpack, classify and order operands so A carries the larger magnitude.
  fp32_unpacked_t ua, ub;
  logic           swap;
  logic           spec_d;
  logic [31:0]    spec_val_d;

  assign ua   = fp32_unpack(x1_q);
  assign ub   = fp32_unpack(x2_q);
  assign swap = {ub.exp, ub.mant} > {ua.exp, ua.mant};

  always_comb begin
    spec_d     = 1'b1;
    spec_val_d = QNAN;
    if (ua.is_nan || ub.is_nan) begin
      spec_val_d = QNAN;
    end else if (ua.is_inf && ub.is_inf) begin
      spec_val_d = (ua.sign == ub.sign) ? (POS_INF | {ua.sign, 31'd0}) : QNAN;
    end else if (ua.is_inf) begin
      spec_val_d = POS_INF | {ua.sign, 31'd0};
    end else if (ub.is_inf) begin
      spec_val_d = POS_INF | {ub.sign, 31'd0};
    end else if (ua.is_zero && ub.is_zero) begin
      spec_val_d = {ua.sign & ub.sign, 31'd0};
    end else begin
      spec_d = 1'b0;
    end
  end

  logic [7:0]  shamt;
  logic [26:0] mb_full, mb_mask, align_mb;

  assign shamt    = a_exp_q - b_exp_q;
  assign mb_full  = {b_mant_q, 3'b000};
  assign mb_mask  = (27'h1 << shamt[4:0]) - 27'h1;
  assign align_mb = (shamt >= 8'd27) ? {26'd0, |b_mant_q}
                  : ((mb_full >> shamt[4:0]) | {26'd0, |(mb_full & mb_mask)});

  logic [27:0] add_sum;
  assign add_sum = (a_sign_q ^ b_sign_q) ? ({1'b0, a_mant_q, 3'b000} - {1'b0, mb_q})
                                         : ({1'b0, a_mant_q, 3'b000} + {1'b0, mb_q});

  // The appended zero makes the count equal the leading zeros of the 27-bit field.
  logic [4:0] lz;
  logic       lz_zero;

  fp32_lzc u_lzc (
    .in_i    ({sum_q[26:0], 1'b0}),
    .count_o (lz),
    .zero_o  (lz_zero)
  );

  logic [26:0] norm_mant;
  logic [9:0]  norm_exp;
  logic        norm_zero, norm_sign;

  always_comb begin
    norm_mant = '0;
    norm_exp  = '0;
    norm_zero = 1'b0;
    norm_sign = a_sign_q;
    if (sum_q[27]) begin
      norm_mant = {sum_q[27:2], sum_q[1] | sum_q[0]};
      norm_exp  = {2'b00, a_exp_q} + 10'd1;
    end else if (lz_zero) begin
      norm_zero = 1'b1;
      norm_sign = 1'b0;
    end else begin
      norm_mant = sum_q[26:0] << lz;
      norm_exp  = {2'b00, a_exp_q} - {5'd0, lz};
      if ($signed(norm_exp) <= 10'sd0) norm_zero = 1'b1;
    end
  end

  logic        round_up;
  logic [24:0] rnd;
  logic [22:0] r_frac;
  logic [9:0]  r_exp;
  logic [31:0] result;

  assign round_up = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
  assign rnd      = {1'b0, mant_q[26:3]} + {24'd0, round_up};
  assign r_frac   = rnd[24] ? rnd[23:1] : rnd[22:0];
  assign r_exp    = exp_q + {9'd0, rnd[24]};

  always_comb begin
    if (special_q)                result = special_val_q;
    else if (zero_q)              result = {sign_q, 31'd0};
    else if (r_exp >= 10'(EXP_MAX)) result = POS_INF | {sign_q, 31'd0};
    else                          result = {sign_q, r_exp[7:0], r_frac};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      x1_q          <= '0;
      x2_q          <= '0;
      a_sign_q      <= 1'b0;
      b_sign_q      <= 1'b0;
      a_exp_q       <= '0;
      b_exp_q       <= '0;
      a_mant_q      <= '0;
      b_mant_q      <= '0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      mb_q          <= '0;
      sum_q         <= '0;
      mant_q        <= '0;
      exp_q         <= '0;
      zero_q        <= 1'b0;
      sign_q        <= 1'b0;
      y_q           <= '0;
      ready_q       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every stage sees last cycle's values.
      state_q <= state_d;
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            x1_q <= x1;
            x2_q <= x2;
          end
        end
        ST_UNPACK: begin
          a_sign_q      <= swap ? ub.sign : ua.sign;
          a_exp_q       <= swap ? ub.exp  : ua.exp;
          a_mant_q      <= swap ? ub.mant : ua.mant;
          b_sign_q      <= swap ? ua.sign : ub.sign;
          b_exp_q       <= swap ? ua.exp  : ub.exp;
          b_mant_q      <= swap ? ua.mant : ub.mant;
          special_q     <= spec_d;
          special_val_q <= spec_val_d;
        end
        ST_ALIGN: mb_q  <= align_mb;
        ST_ADD:   sum_q <= add_sum;
        ST_NORM: begin
          mant_q <= norm_mant;
          exp_q  <= norm_exp;
          zero_q <= norm_zero;
          sign_q <= norm_sign;
        end
        ST_ROUND: begin
          y_q     <= result;
          ready_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign y     = y_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_fp32add.sv
// Directed bench for fp32add: expected sums go into a scoreboard queue when an
// operation is accepted and are popped against y on each ready pulse.
module tb_fp32add;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x1, x2;
  logic        en;
  logic [31:0] y;
  logic        ready;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [31:0] sb[$];

  fp32add dut (
    .clk   (clk),
    .rst   (rst),
    .x1    (x1),
    .x2    (x2),
    .en    (en),
    .y     (y),
    .ready (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic start(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input bit push);
    x1 = a;
    x2 = b;
    en = 1'b1;
    if (push) sb.push_back(expv);
    @(negedge clk);
    en = 1'b0;
    x1 = $urandom;
    x2 = $urandom;
  endtask

  // lat0 = negedges already elapsed since the one following the accepting edge.
  task automatic finish_op(input string tag, input int lat0);
    int lat;
    logic [31:0] e;
    lat = lat0;
    while (!ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd5);
    e = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    check(tag, y, e);
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv);
    @(negedge clk);
    start(a, b, expv, 1'b1);
    finish_op(tag, 0);
    @(negedge clk);
    check({tag, " pulse width"}, {31'd0, ready}, 32'd0);
  endtask

  task automatic no_ready(input string tag, input int n);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (ready) cnt++;
    end
    check(tag, 32'(cnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    x1  = '0;
    x2  = '0;
    repeat (3) @(negedge clk);
    check("reset y", y, 32'h0000_0000);
    check("reset ready", {31'd0, ready}, 32'd0);

    // en together with reset must not be accepted.
    x1 = 32'h3F80_0000;
    x2 = 32'h3F80_0000;
    en = 1'b1;
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
    no_ready("en under reset ignored", 8);

    // Back-to-back: second request issued in the ready cycle.
    @(negedge clk);
    start(32'h4040_0000, 32'h4140_0000, 32'h4170_0000, 1'b1);
    finish_op("b2b 3+12", 0);
    start(32'hC070_0000, 32'h4070_0000, 32'h0000_0000, 1'b1);
    check("b2b ready single", {31'd0, ready}, 32'd0);
    finish_op("b2b -3.75+3.75", 0);

    do_op("tie to even",     32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    do_op("round up",        32'h3F80_0000, 32'h3400_0000, 32'h3F80_0001);
    do_op("cancellation",    32'h3F80_0000, 32'hBF7F_FFFF, 32'h3380_0000);
    do_op("large shift",     32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000);
    do_op("inf minus inf",   32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    do_op("overflow",        32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    do_op("nan input",       32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
    do_op("neg zero sum",    32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    do_op("inf plus finite", 32'hFF80_0000, 32'h4040_0000, 32'hFF80_0000);
    do_op("swap operands",   32'h3F80_0000, 32'hC040_0000, 32'hC000_0000);

    // en pulsed during ALIGN with other operands is ignored.
    @(negedge clk);
    start(32'h4040_0000, 32'h4140_0000, 32'h4170_0000, 1'b1);
    @(negedge clk);
    x1 = 32'h3F80_0000;
    x2 = 32'h3F80_0000;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    finish_op("busy en ignored", 2);
    no_ready("busy no second result", 10);

    // Reset during ADD aborts the operation.
    @(negedge clk);
    start(32'h4040_0000, 32'h4140_0000, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort y cleared", y, 32'h0000_0000);
    check("abort ready", {31'd0, ready}, 32'd0);
    no_ready("abort no ready", 8);
    do_op("after abort 1+1", 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);

    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
